feature_mem_responder: RTL and testbench
========================================

Name: feature_mem_responder

Overview:
- Memory-side responder for the layer controller's address/read/write interface.
- Holds byte-addressed feature maps as DEPTH 32-bit words: 4 bytes per word, byte lane selected by memory_offset.
- Serves controller reads with 1-cycle latency and accepts single-byte lane writes.
- On a writeOut pulse, streams a window of words to an external sink over a valid/ready handshake.

Parameters:
- DEPTH, 64, number of 32-bit words in the array.
- ADDR_W, 8, width of address and out_addr.
- DUMP_WORDS, 43, words streamed per dump, starting at word 0 (13x13 bytes = 169 bytes -> 43 words). Legal range 1..DEPTH.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- address  in  ADDR_W  word address; sampled only when read or write_en is 1 (may be Z otherwise).
- memory_offset  in  2  byte lane within the word for writes; sampled only when write_en is 1.
- write_en  in  1  byte write strobe.
- wdata  in  8  byte to write.
- read  in  1  read request.
- rdata  out  32  read data, bytes packed lane3..lane0 MSB..LSB.
- rvalid  out  1  rdata valid, exactly one cycle after read.
- writeOut  in  1  dump start request (level or pulse).
- out_valid  out  1  dump word valid.
- out_ready  in  1  sink accepts the word.
- out_data  out  32  dump word.
- out_addr  out  ADDR_W  word index of out_data.
- out_last  out  1  high with the final dump word.
- dump_busy  out  1  high from dump start until the final handshake.
- dump_done  out  1  one-cycle pulse after the final handshake.
- wr_dropped  out  1  sticky; set when a write is discarded.

Behaviour:
- Reset (reset=0, async): all outputs and state go to 0 (rdata, rvalid, out_*, dump_busy, dump_done, wr_dropped); FSM enters IDLE. Array contents are not cleared.
- Write:
  - On the edge with write_en=1 and address<DEPTH: byte lane memory_offset of word[address] <= wdata. Other lanes are unchanged.
  - address>=DEPTH: write is ignored and wr_dropped is set.
- Read:
  - On the edge with read=1: next cycle rvalid=1 and rdata = word[address], or 0 if address>=DEPTH.
  - rdata holds its value until the next read; rvalid is otherwise 0.
  - Read and write to the same word in the same cycle: rdata returns the pre-write value.
  - Back-to-back reads give one rvalid per read.
- Dump FSM:
  - IDLE: writeOut=1 -> FETCH, ptr=0, dump_busy=1. A writeOut held high is edge-insensitive; it is ignored while busy.
  - FETCH: issue an internal array read of word[ptr].
    - If read=1 this cycle, the controller read has priority and FETCH stalls.
    - Otherwise -> SHOW, and the word is latched into out_data.
  - SHOW: out_valid=1, out_addr=ptr, out_last=(ptr==DUMP_WORDS-1). out_data, out_addr and out_last are stable while out_ready=0.
    - On out_valid && out_ready: if last -> IDLE, dump_busy=0, dump_done=1 for one cycle. Else ptr++ -> FETCH.
  - Throughput is at most one word per 2 cycles.
  - writeOut high on the cycle dump_done pulses starts a new dump immediately.
- Writes during a dump (dump_busy=1) are discarded and set wr_dropped. The dumped image is therefore a consistent snapshot.
- Controller reads during a dump are serviced normally.
- wr_dropped clears only on reset.
- Reset mid-dump: the dump aborts, out_valid drops asynchronously, and no dump_done is issued.

Decomposition:
- Shared package, also imported by the controller:
  - dump FSM state enum (IDLE, FETCH, SHOW);
  - BYTES_PER_WORD=4;
  - L1_OUT_WORDS=43;
  - L2_OUT_WORDS=25.
- One sub-module, byte_lane_ram: DEPTH x 32 single array with a per-lane write enable, one registered read port and one internal dump read port (mux selected by the FSM).

Test Plan:
- Reset release, then write 0xAA, 0xBB, 0xCC, 0xDD to word 5 lanes 0..3, then read 5 -> next cycle rvalid=1, rdata=0xDDCCBBAA.
- Write 0x11 to word 5 lane 2 and read 5 in the same cycle -> rdata=0xDDCCBBAA. Following read -> 0xDD11BBAA.
- Write to address 70 (DEPTH=64) -> array unchanged, wr_dropped=1. Read 70 -> rdata=0, rvalid=1.
- Preload words 0..42 with value=index, pulse writeOut, out_ready toggling 1,0,0,1 -> 43 handshakes with out_addr 0..42 and out_data=index. out_last only at 42; dump_done one cycle later.
- During a dump, issue write_en to word 3 and read word 10 on the FETCH cycle:
  - write dropped, wr_dropped=1;
  - rvalid with word 10;
  - FETCH stalls one cycle;
  - stream still correct.
- Assert reset=0 while out_valid=1 at ptr=20 -> all outputs 0 immediately. After release, writeOut restarts the dump from out_addr=0.

Source files
------------

// File: rtl/feature_mem_responder_pkg.sv
// Shared definitions for the feature memory responder and the layer controller.
package feature_mem_responder_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      SHOW  = 2'd2
   } dump_state_e;

   localparam int BYTES_PER_WORD = 4;
   localparam int WORD_W         = 8 * BYTES_PER_WORD;
   localparam int L1_OUT_WORDS   = 43;
   localparam int L2_OUT_WORDS   = 25;

endpackage

// File: rtl/feature_mem_responder_byte_lane_ram.sv
// DEPTH x 32 byte-lane-writable array; one shared read mux feeding a controller
// read register and a dump word register.
module feature_mem_responder_byte_lane_ram
   import feature_mem_responder_pkg::*;
#(
   parameter int DEPTH = 64,
   parameter int IDX_W = 6
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              wr_en_i,
   input  logic [1:0]        wr_lane_i,
   input  logic [IDX_W-1:0]  wr_idx_i,
   input  logic [7:0]        wr_byte_i,
   input  logic              ctrl_rd_i,
   input  logic              ctrl_ok_i,
   input  logic [IDX_W-1:0]  ctrl_idx_i,
   input  logic              dump_rd_i,
   input  logic [IDX_W-1:0]  dump_idx_i,
   output logic [WORD_W-1:0] rdata_o,
   output logic [WORD_W-1:0] dump_data_o
);

   logic [WORD_W-1:0] mem_q [DEPTH];
   logic [IDX_W-1:0]  rd_idx_s;
   logic [WORD_W-1:0] rd_word_s;
   logic [WORD_W-1:0] rdata_q;
   logic [WORD_W-1:0] dump_q;

   // Controller reads own the single read mux; the dump port only uses idle slots.
   assign rd_idx_s  = ctrl_rd_i ? ctrl_idx_i : dump_idx_i;
   assign rd_word_s = mem_q[rd_idx_s];

   // Byte-lane write; array contents survive reset.
   always_ff @(posedge clock) begin
      if (wr_en_i) begin
         mem_q[wr_idx_i][{wr_lane_i, 3'b000} +: 8] <= wr_byte_i;
      end
   end

   // Read registers sample the pre-write word and hold until their next access.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rdata_q <= '0;
         dump_q  <= '0;
      end else begin
         if (ctrl_rd_i) begin
            rdata_q <= ctrl_ok_i ? rd_word_s : '0;
         end
         if (dump_rd_i) begin
            dump_q <= rd_word_s;
         end
      end
   end

   assign rdata_o     = rdata_q;
   assign dump_data_o = dump_q;

endmodule

// File: rtl/feature_mem_responder.sv
// Memory-side responder: byte writes, 1-cycle reads, and a valid/ready dump of
// the first DUMP_WORDS words taken as a write-locked snapshot.
module feature_mem_responder
   import feature_mem_responder_pkg::*;
#(
   parameter int DEPTH      = 64,
   parameter int ADDR_W     = 8,
   parameter int DUMP_WORDS = L1_OUT_WORDS
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [ADDR_W-1:0] address,
   input  logic [1:0]        memory_offset,
   input  logic              write_en,
   input  logic [7:0]        wdata,
   input  logic              read,
   output logic [WORD_W-1:0] rdata,
   output logic              rvalid,
   input  logic              writeOut,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WORD_W-1:0] out_data,
   output logic [ADDR_W-1:0] out_addr,
   output logic              out_last,
   output logic              dump_busy,
   output logic              dump_done,
   output logic              wr_dropped
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   dump_state_e       state_q;
   logic [ADDR_W-1:0] ptr_q;
   logic              rvalid_q;
   logic              out_valid_q;
   logic              out_last_q;
   logic              dump_busy_q;
   logic              dump_done_q;
   logic              wr_dropped_q;

   logic addr_ok_s;
   logic wr_ok_s;
   logic wr_drop_s;
   logic dump_rd_s;
   logic last_s;

   // Writes are locked out for the whole dump so the streamed image is consistent.
   assign addr_ok_s = {1'b0, address} < (ADDR_W+1)'(DEPTH);
   assign wr_ok_s   = write_en & addr_ok_s & ~dump_busy_q;
   assign wr_drop_s = write_en & ~wr_ok_s;
   assign dump_rd_s = (state_q == FETCH) & ~read;
   assign last_s    = (ptr_q == ADDR_W'(DUMP_WORDS - 1));

   feature_mem_responder_byte_lane_ram #(
      .DEPTH (DEPTH),
      .IDX_W (IDX_W)
   ) u_byte_lane_ram (
      .clock       (clock),
      .reset       (reset),
      .wr_en_i     (wr_ok_s),
      .wr_lane_i   (memory_offset),
      .wr_idx_i    (address[IDX_W-1:0]),
      .wr_byte_i   (wdata),
      .ctrl_rd_i   (read),
      .ctrl_ok_i   (addr_ok_s),
      .ctrl_idx_i  (address[IDX_W-1:0]),
      .dump_rd_i   (dump_rd_s),
      .dump_idx_i  (ptr_q[IDX_W-1:0]),
      .rdata_o     (rdata),
      .dump_data_o (out_data)
   );

   // Dump FSM, read-valid pipeline and sticky drop flag.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         ptr_q        <= '0;
         rvalid_q     <= 1'b0;
         out_valid_q  <= 1'b0;
         out_last_q   <= 1'b0;
         dump_busy_q  <= 1'b0;
         dump_done_q  <= 1'b0;
         wr_dropped_q <= 1'b0;
      end else begin
         rvalid_q     <= read;
         dump_done_q  <= 1'b0;
         wr_dropped_q <= wr_dropped_q | wr_drop_s;
         case (state_q)
            IDLE: begin
               if (writeOut) begin
                  state_q     <= FETCH;
                  ptr_q       <= '0;
                  dump_busy_q <= 1'b1;
               end
            end
            FETCH: begin
               if (!read) begin
                  state_q     <= SHOW;
                  out_valid_q <= 1'b1;
                  out_last_q  <= last_s;
               end
            end
            SHOW: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  if (out_last_q) begin
                     state_q     <= IDLE;
                     out_last_q  <= 1'b0;
                     dump_busy_q <= 1'b0;
                     dump_done_q <= 1'b1;
                  end else begin
                     state_q <= FETCH;
                     ptr_q   <= ptr_q + ADDR_W'(1);
                  end
               end
            end
            default: begin
               state_q     <= IDLE;
               out_valid_q <= 1'b0;
               out_last_q  <= 1'b0;
               dump_busy_q <= 1'b0;
            end
         endcase
      end
   end

   assign rvalid     = rvalid_q;
   assign out_valid  = out_valid_q;
   assign out_addr   = ptr_q;
   assign out_last   = out_last_q;
   assign dump_busy  = dump_busy_q;
   assign dump_done  = dump_done_q;
   assign wr_dropped = wr_dropped_q;

endmodule

// File: tb/tb_feature_mem_responder.sv
// Bench for feature_mem_responder: vector table for write/read, scoreboard for
// reads and dump stream, directed sequences for dump corner cases.
module tb_feature_mem_responder;

   logic        clock;
   logic        reset;
   logic [7:0]  address;
   logic [1:0]  memory_offset;
   logic        write_en;
   logic [7:0]  wdata;
   logic        read;
   logic [31:0] rdata;
   logic        rvalid;
   logic        writeOut;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic [7:0]  out_addr;
   logic        out_last;
   logic        dump_busy;
   logic        dump_done;
   logic        wr_dropped;

   feature_mem_responder dut (
      .clock         (clock),
      .reset         (reset),
      .address       (address),
      .memory_offset (memory_offset),
      .write_en      (write_en),
      .wdata         (wdata),
      .read          (read),
      .rdata         (rdata),
      .rvalid        (rvalid),
      .writeOut      (writeOut),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_data      (out_data),
      .out_addr      (out_addr),
      .out_last      (out_last),
      .dump_busy     (dump_busy),
      .dump_done     (dump_done),
      .wr_dropped    (wr_dropped)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic        we;
      logic [7:0]  addr;
      logic [1:0]  lane;
      logic [7:0]  wd;
      logic        rd;
      logic [31:0] exp_rd;
      logic        exp_drop;
   } vec_t;

   typedef struct packed {
      logic [7:0]  a;
      logic [31:0] d;
      logic        l;
   } dw_t;

   localparam int NV = 21;
   vec_t        tv [NV];
   logic [31:0] rq [$];
   dw_t         dq [$];
   dw_t         mon_e;
   logic [31:0] mon_r;
   logic        exp_done = 1'b0;
   int          done_cnt = 0;
   int          n_tests  = 0;
   int          n_fail   = 0;
   logic [3:0]  pat      = 4'b1001;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_rdata"},      64'(rdata),      64'd0);
      chk({tag, "_rvalid"},     64'(rvalid),     64'd0);
      chk({tag, "_out_valid"},  64'(out_valid),  64'd0);
      chk({tag, "_out_data"},   64'(out_data),   64'd0);
      chk({tag, "_out_addr"},   64'(out_addr),   64'd0);
      chk({tag, "_out_last"},   64'(out_last),   64'd0);
      chk({tag, "_dump_busy"},  64'(dump_busy),  64'd0);
      chk({tag, "_dump_done"},  64'(dump_done),  64'd0);
      chk({tag, "_wr_dropped"}, 64'(wr_dropped), 64'd0);
   endtask

   task automatic wr_byte(input logic [7:0] a, input logic [1:0] l, input logic [7:0] d);
      write_en      = 1'b1;
      address       = a;
      memory_offset = l;
      wdata         = d;
      @(posedge clock); #1;
      write_en = 1'b0;
   endtask

   task automatic push_dump();
      for (int i = 0; i < 43; i++) begin
         dq.push_back('{a: 8'(i), d: 32'(i), l: (i == 42)});
      end
   endtask

   task automatic run_dump(input string tag);
      int         start;
      logic [1:0] k;
      start = done_cnt;
      k     = 2'd0;
      for (int c = 0; c < 1000 && done_cnt == start; c++) begin
         out_ready = pat[k];
         k++;
         @(posedge clock); #1;
      end
      out_ready = 1'b0;
      chk({tag, "_done_count"}, 64'(done_cnt - start), 64'd1);
      chk({tag, "_words_left"}, 64'(dq.size()), 64'd0);
   endtask

   // Scoreboard monitor, sampled on the falling edge.
   always @(negedge clock) begin
      if (reset) begin
         if (exp_done) begin
            chk("dump_done", 64'(dump_done), 64'd1);
            if (dump_done) done_cnt++;
            exp_done = 1'b0;
         end else if (dump_done) begin
            chk("dump_done_spurious", 64'(dump_done), 64'd0);
         end
         if (rvalid) begin
            if (rq.size() == 0) begin
               chk("rvalid_unexpected", 64'(rvalid), 64'd0);
            end else begin
               mon_r = rq.pop_front();
               chk("rdata", 64'(rdata), 64'(mon_r));
            end
         end
         if (out_valid && out_ready) begin
            if (dq.size() == 0) begin
               chk("handshake_unexpected", 64'(out_valid), 64'd0);
            end else begin
               mon_e = dq.pop_front();
               chk("dump_word", {23'd0, out_addr, out_data, out_last}, {23'd0, mon_e});
               if (out_last) exp_done = 1'b1;
            end
         end
      end
   end

   initial begin
      tv[0]  = '{1'b1, 8'd63,  2'd0, 8'h3C, 1'b0, 32'h0,        1'b0};
      tv[1]  = '{1'b1, 8'd63,  2'd1, 8'h2B, 1'b0, 32'h0,        1'b0};
      tv[2]  = '{1'b1, 8'd63,  2'd2, 8'h1A, 1'b0, 32'h0,        1'b0};
      tv[3]  = '{1'b1, 8'd63,  2'd3, 8'h09, 1'b0, 32'h0,        1'b0};
      tv[4]  = '{1'b0, 8'd63,  2'd0, 8'h00, 1'b1, 32'h091A2B3C, 1'b0};
      tv[5]  = '{1'b1, 8'd5,   2'd0, 8'hAA, 1'b0, 32'h0,        1'b0};
      tv[6]  = '{1'b1, 8'd5,   2'd1, 8'hBB, 1'b0, 32'h0,        1'b0};
      tv[7]  = '{1'b1, 8'd5,   2'd2, 8'hCC, 1'b0, 32'h0,        1'b0};
      tv[8]  = '{1'b1, 8'd5,   2'd3, 8'hDD, 1'b0, 32'h0,        1'b0};
      tv[9]  = '{1'b0, 8'd5,   2'd0, 8'h00, 1'b1, 32'hDDCCBBAA, 1'b0};
      tv[10] = '{1'b1, 8'd5,   2'd2, 8'h11, 1'b1, 32'hDDCCBBAA, 1'b0};
      tv[11] = '{1'b0, 8'd5,   2'd0, 8'h00, 1'b1, 32'hDD11BBAA, 1'b0};
      tv[12] = '{1'b1, 8'd70,  2'd1, 8'h55, 1'b0, 32'h0,        1'b1};
      tv[13] = '{1'b1, 8'd69,  2'd0, 8'h66, 1'b0, 32'h0,        1'b1};
      tv[14] = '{1'b0, 8'd70,  2'd0, 8'h00, 1'b1, 32'h0,        1'b1};
      tv[15] = '{1'b0, 8'd5,   2'd0, 8'h00, 1'b1, 32'hDD11BBAA, 1'b1};
      tv[16] = '{1'b0, 8'd5,   2'd0, 8'h00, 1'b1, 32'hDD11BBAA, 1'b1};
      tv[17] = '{1'b1, 8'd5,   2'd3, 8'h00, 1'b0, 32'h0,        1'b1};
      tv[18] = '{1'b0, 8'd5,   2'd0, 8'h00, 1'b1, 32'h0011BBAA, 1'b1};
      tv[19] = '{1'b0, 8'd255, 2'd0, 8'h00, 1'b1, 32'h0,        1'b1};
      tv[20] = '{1'b0, 8'd63,  2'd0, 8'h00, 1'b1, 32'h091A2B3C, 1'b1};

      clock = 1'b0; reset = 1'b1; address = 8'd0; memory_offset = 2'd0;
      write_en = 1'b0; wdata = 8'd0; read = 1'b0; writeOut = 1'b0; out_ready = 1'b0;

      #2 reset = 1'b0;
      #1 check_zero("reset");
      @(posedge clock); @(posedge clock); #1;
      reset = 1'b1;
      @(posedge clock); #1;

      for (int i = 0; i < NV; i++) begin
         write_en      = tv[i].we;
         address       = tv[i].addr;
         memory_offset = tv[i].lane;
         wdata         = tv[i].wd;
         read          = tv[i].rd;
         if (tv[i].rd) rq.push_back(tv[i].exp_rd);
         @(posedge clock); #1;
         chk("wr_dropped", 64'(wr_dropped), 64'(tv[i].exp_drop));
      end
      write_en = 1'b0;
      read     = 1'b0;
      @(posedge clock); #1;
      chk("reads_pending", 64'(rq.size()), 64'd0);
      chk("rvalid_idle", 64'(rvalid), 64'd0);

      for (int i = 0; i < 43; i++) begin
         for (int l = 0; l < 4; l++) begin
            wr_byte(8'(i), 2'(l), (l == 0) ? 8'(i) : 8'd0);
         end
      end

      // Full dump with ready pattern 1,0,0,1.
      push_dump();
      writeOut = 1'b1;
      @(posedge clock); #1;
      writeOut = 1'b0;
      chk("busy_after_start", 64'(dump_busy), 64'd1);
      run_dump("dump1");
      chk("busy_after_done", 64'(dump_busy), 64'd0);

      // Reset while word 20 is on offer.
      push_dump();
      writeOut  = 1'b1;
      out_ready = 1'b1;
      @(posedge clock); #1;
      writeOut = 1'b0;
      for (int c = 0; c < 500; c++) begin
         if (out_valid && out_addr == 8'd20) break;
         @(posedge clock); #1;
      end
      chk("reached_word20", 64'(out_valid && out_addr == 8'd20), 64'd1);
      reset = 1'b0;
      #1 check_zero("midreset");
      dq.delete();
      exp_done  = 1'b0;
      out_ready = 1'b0;
      @(posedge clock); #1;
      reset = 1'b1;
      @(posedge clock); #1;

      // Restart with a controller read on the FETCH cycle, then a dropped write.
      push_dump();
      writeOut = 1'b1;
      @(posedge clock); #1;
      writeOut = 1'b0;
      chk("busy_restart", 64'(dump_busy), 64'd1);
      read    = 1'b1;
      address = 8'd10;
      rq.push_back(32'd10);
      @(posedge clock); #1;
      read          = 1'b0;
      write_en      = 1'b1;
      address       = 8'd3;
      memory_offset = 2'd0;
      wdata         = 8'hEE;
      chk("fetch_stall", 64'(out_valid), 64'd0);
      @(posedge clock); #1;
      write_en = 1'b0;
      chk("show_after_stall", 64'(out_valid), 64'd1);
      chk("restart_first_addr", 64'(out_addr), 64'd0);
      chk("wr_dropped_in_dump", 64'(wr_dropped), 64'd1);
      run_dump("dump2");
      chk("reads_pending_dump", 64'(rq.size()), 64'd0);

      // writeOut held high: ignored while busy, restarts on the dump_done cycle.
      push_dump();
      writeOut = 1'b1;
      run_dump("dump3");
      chk("restart_on_done", 64'(dump_busy), 64'd1);
      writeOut = 1'b0;
      push_dump();
      run_dump("dump4");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
